// File: rtl/serial_adder_seq.sv
// Bit-serial adder sequencer driving an external 1-bit full-adder cell.
// Optional signed-overflow output enabled by defining SERADD_OVF_EN.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
`ifdef SERADD_OVF_EN
    input  logic             fa_cout,
    output logic             ovf
`else
    input  logic             fa_cout
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;

    assign last = (cnt == CW'(WIDTH - 1));

    // Cell inputs come straight from flops, gated by the busy flop.
    assign fa_a   = a_sr[0] & busy;
    assign fa_b   = b_sr[0] & busy;
    assign fa_cin = carry & busy;

    // Sequencer: load, shift one bit per cycle, publish result for a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum_out  <= '0;
            cout_out <= 1'b0;
`ifdef SERADD_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a_in;
                        b_sr  <= b_in;
                        carry <= cin_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
                    carry  <= fa_cout;
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    if (last) begin
                        cnt      <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sum_out  <= {fa_sum, sum_sr[WIDTH-1:1]};
                        cout_out <= fa_cout;
`ifdef SERADD_OVF_EN
                        // carry holds the carry into the MSB here
                        ovf      <= carry ^ fa_cout;
`endif
                        state    <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Randomized self-checking bench for serial_adder_seq.
// Models the full-adder cell and checks results against plain arithmetic.
module tb_serial_adder_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         cin_in = 1'b0;
    logic         busy, done, cout_out;
    logic [W-1:0] sum_out;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
`ifdef SERADD_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    always #10 clk = ~clk;

    // external full-adder cell
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    serial_adder_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .busy(busy), .done(done),
        .sum_out(sum_out), .cout_out(cout_out),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum),
`ifdef SERADD_OVF_EN
        .fa_cout(fa_cout), .ovf(ovf)
`else
        .fa_cout(fa_cout)
`endif
    );

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Runs one add starting at the current negedge (IDLE cycle).
    // Returns at the negedge of the IDLE cycle after DONE.
    task automatic run_add(input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input logic cin,
                           input bit inject);
        int unsigned full, mask, cexp;
        int sa, sb, ss;
        full = int'(a) + int'(b) + int'(cin);
        a_in = a; b_in = b; cin_in = cin; start = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = 1'b0;
            mask = (32'd1 << i) - 1;
            cexp = ((int'(a) & mask) + (int'(b) & mask) + int'(cin)) >> i;
            chk($sformatf("busy%0d", i), 32'(busy), 32'd1);
            chk($sformatf("fa_a%0d", i), 32'(fa_a), 32'(a[i]));
            chk($sformatf("fa_b%0d", i), 32'(fa_b), 32'(b[i]));
            chk($sformatf("fa_cin%0d", i), 32'(fa_cin), cexp & 1);
            if (inject && i == 2) begin
                start = 1'b1; a_in = ~a; b_in = a ^ 8'h33; cin_in = ~cin;
            end
        end
        @(negedge clk);
        start = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("busy_d", 32'(busy), 32'd0);
        chk("sum", 32'(sum_out), full & 32'hFF);
        chk("cout", 32'(cout_out), (full >> W) & 1);
        chk("fa_idle", 32'({fa_a, fa_b, fa_cin}), 32'd0);
`ifdef SERADD_OVF_EN
        sa = int'($signed(a)); sb = int'($signed(b));
        ss = sa + sb + int'(cin);
        chk("ovf", 32'(ovf), 32'((ss > 127) || (ss < -128)));
`endif
        if (inject) begin
            start = 1'b1; a_in = 8'hA5; b_in = 8'h11;
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_i", 32'(busy), 32'd0);
        chk("sum_hold", 32'(sum_out), full & 32'hFF);
    endtask

    initial begin
        int n0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum", 32'(sum_out), 32'd0);
        chk("rst_cout", 32'(cout_out), 32'd0);
        chk("rst_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
`ifdef SERADD_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_add(8'h5A, 8'h3C, 1'b0, 0);
        run_add(8'hFF, 8'h01, 1'b0, 0);
        run_add(8'hFF, 8'h00, 1'b1, 0);
        run_add(8'h00, 8'h00, 1'b0, 0);

        // starts during SHIFT and DONE must be ignored
        n0 = done_cnt;
        run_add(8'h27, 8'h6E, 1'b1, 1);
        repeat (3) @(negedge clk);
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_once", 32'(done_cnt - n0), 32'd1);

        // reset mid-operation
        n0 = done_cnt;
        a_in = 8'hC3; b_in = 8'h5D; cin_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_sum", 32'(sum_out), 32'd0);
        chk("ar_cout", 32'(cout_out), 32'd0);
        chk("ar_fa", 32'({fa_a, fa_b, fa_cin}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        chk("ar_nodone", 32'(done_cnt - n0), 32'd0);
        chk("ar_idle", 32'(busy), 32'd0);
        run_add(8'hC3, 8'h5D, 1'b1, 0);

`ifdef SERADD_OVF_EN
        run_add(8'h7F, 8'h01, 1'b0, 0);
        run_add(8'h80, 8'h80, 1'b0, 0);
        run_add(8'h10, 8'h20, 1'b0, 0);
`endif

        for (int k = 0; k < 24; k++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
